// File: rtl/branch_flush_ctrl.sv
// Branch resolution / pipeline flush controller for the EX stage.
// Holds the front end while a branch operand is pending, redirects fetch to
// a latched target on a taken branch, and pulses the link-register write.
// Optional feature macro: BRANCH_STATS_EN adds resolved/taken branch counters
// with a synchronous clear input.
module branch_flush_ctrl (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iBranchValid,
  input  logic        iBranch,
  input  logic        iLink,
  input  logic [31:0] iTarget,
  input  logic [31:0] iPCPlus4,
  input  logic        iOperandBusy,
  input  logic        iFetchReady,
`ifdef BRANCH_STATS_EN
  input  logic        iStatsClr,
  output logic [31:0] oBranchCount,
  output logic [31:0] oTakenCount,
`endif
  output logic        oStall,
  output logic        oFlushIFID,
  output logic        oFlushIDEX,
  output logic        oPCSel,
  output logic [31:0] oPCTarget,
  output logic        oLinkWrite,
  output logic [31:0] oLinkData,
  output logic [1:0]  oState
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] target_q, target_d;
  logic          resolve_c;

  // State and latched redirect target.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next state and outputs; outputs respond in the same cycle and are forced
  // low while reset is held.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    resolve_c  = 1'b0;
    oStall     = 1'b0;
    oFlushIFID = 1'b0;
    oFlushIDEX = 1'b0;
    oPCSel     = 1'b0;
    oPCTarget  = '0;
    oLinkWrite = 1'b0;
    oLinkData  = '0;

    case (state_q)
      IDLE: begin
        if (iBranchValid) begin
          if (iOperandBusy) begin
            oStall  = 1'b1;
            state_d = HOLD;
          end else begin
            resolve_c = 1'b1;
          end
        end
      end
      HOLD: begin
        oStall = 1'b1;
        if (!iBranchValid) begin
          state_d = IDLE;
        end else if (!iOperandBusy) begin
          resolve_c = 1'b1;
        end
      end
      REDIRECT: begin
        // Anything in EX now is wrong-path, so iBranchValid is not looked at.
        oPCSel     = 1'b1;
        oPCTarget  = target_q;
        oFlushIFID = 1'b1;
        oFlushIDEX = 1'b1;
        if (iFetchReady) begin
          state_d = IDLE;
        end else begin
          oStall = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (resolve_c) begin
      if (iLink) begin
        oLinkWrite = 1'b1;
        oLinkData  = iPCPlus4;
      end
      if (iBranch) begin
        target_d = iTarget;
        state_d  = REDIRECT;
      end else begin
        state_d = IDLE;
      end
    end

    if (!iRST) begin
      oStall     = 1'b0;
      oFlushIFID = 1'b0;
      oFlushIDEX = 1'b0;
      oPCSel     = 1'b0;
      oPCTarget  = '0;
      oLinkWrite = 1'b0;
      oLinkData  = '0;
    end
  end

  assign oState = 2'(state_q);

`ifdef BRANCH_STATS_EN
  logic [AW-1:0] branch_cnt_q, taken_cnt_q;

  // Resolved / taken counters; clear has priority over a same-cycle count.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (iStatsClr) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      if (resolve_c) begin
        branch_cnt_q <= branch_cnt_q + AW'(1);
      end
      if (resolve_c && iBranch) begin
        taken_cnt_q <= taken_cnt_q + AW'(1);
      end
    end
  end

  assign oBranchCount = branch_cnt_q;
  assign oTakenCount  = taken_cnt_q;
`endif

endmodule
